fp_div: RTL and testbench
=========================

# fp_div

Sequential single-precision floating-point divider: Out = InA / InB in IEEE-754 binary32 layout. It is the inverse of the combinational multiplier in the FP datapath. It uses a restoring mantissa divider at one quotient bit per clock, with a Start/Busy/Done handshake. Output semantics match the multiplier: truncation, no rounding, no overflow or underflow detection, and zero special-casing.

## Interface
- Parameters: none. The format is fixed at binary32.
- Clk  in  1  clock; all state updates on rising edge
- Rst_n  in  1  asynchronous, active-low reset
- Start  in  1  request; sampled only in IDLE
- En  in  1  output enable (see Configuration)
- InA  in  32  dividend, captured when Start is accepted
- InB  in  32  divisor, captured when Start is accepted
- Out  out  32  result register; holds until the next accepted Start completes
- Busy  out  1  high from accepted Start until the result is written
- Done  out  1  one-cycle pulse when Out is updated

## Operation
- States: IDLE, CALC, NORM.
- IDLE:
  - Start=1 at edge E0 captures InA and InB.
  - Sign = InA[31]^InB[31].
  - ExpTmp = InA[30:23] - InB[30:23] + 8'd127, modulo 2^8.
  - Remainder = {1'b1,InA[22:0]}; Divisor = {1'b1,InB[22:0]}; bit counter = 24.
  - Busy<=1; go to CALC.
- CALC, each edge E1..E25:
  - Trial = Remainder - Divisor.
  - If Trial is non-negative: quotient bit 1 and Remainder = Trial. Otherwise quotient bit 0 and Remainder is unchanged.
  - Remainder <<= 1. Quotient Q[24:0] fills MSB first.
  - Counter decrements; at E25 (counter 0) go to NORM.
- NORM, edge E26:
  - Q[24]=1: Fraction = Q[23:1], Exponent = ExpTmp.
  - Q[24]=0 (then Q[23]=1): Fraction = Q[22:0], Exponent = ExpTmp - 1.
  - Priority overrides:
    - captured InA==0: Out = 32'd0.
    - otherwise, captured InB==0: Out = {Sign,8'hFF,23'd0}.
    - otherwise: Out = {Sign,Exponent,Fraction}.
  - Done<=1, Busy<=0; go to IDLE.
- The zero check is on the full 32-bit word, so -0.0 is not zero. Denormal inputs are treated as normal, with an implicit leading 1.
- Start while Busy=1 is ignored. Start in the cycle Done=1 is accepted (the state is IDLE).
- Zero operands still take the full fixed latency.

## Timing
- Reset values: Out=0, Busy=0, Done=0, state IDLE, internal registers 0.
- Latency is fixed: Done asserts 26 clocks after the Start-accepting edge. Back-to-back throughput is 1 result per 27 clocks.
- Done is high for exactly one cycle, coincident with the first cycle the new Out is valid.
- Rst_n low mid-operation aborts the operation immediately: no Done pulse, Out returns to 0.
- Inputs are don't-care after capture. Changing InA/InB while Busy has no effect.
- Exponent wrap-around is silent, as in the multiplier.

## Configuration
- FP_DIV_TRISTATE_EN defined: Out = En ? result register : 32'hZZZZZZZZ. This makes the block shareable on the FP result bus alongside the multiplier.
- FP_DIV_TRISTATE_EN undefined: En is ignored and Out always drives the result register.
- Busy and Done are never tri-stated.

## Structure
- Package fp_pkg:
  - binary32 field widths (EXP_W=8, FRAC_W=23, MANT_W=24).
  - BIAS=8'd127; QUOT_W=25.
  - FP_INF_EXP=8'hFF.
  - State enum {IDLE, CALC, NORM}.
- Sub-module fp_div_normalize: combinational; takes Q[24:0] and ExpTmp, returns Fraction and Exponent per the NORM rules.
- Top level holds the FSM, the datapath registers and the output muxing.

## Test plan
- 6.0/2.0: InA=0x40C00000, InB=0x40000000 -> Out=0x40400000; Done exactly 26 clocks after Start; Busy high throughout.
- 1.0/3.0: InA=0x3F800000, InB=0x40400000 -> Out=0x3EAAAAAA (truncated; exercises the Q[24]=0 path).
- Signs and zeros: -8.0/2.0 = 0xC1000000/0x40000000 -> 0xC0800000. 0x00000000/0x40000000 -> 0x00000000. 0x3F800000/0x00000000 -> 0x7F800000.
- Handshake: a Start pulse at cycle 5 of a busy operation is ignored and the first result is unaffected. Start in the Done cycle is accepted and its result follows 26 clocks later.
- Reset: Rst_n low at cycle 10 of an operation -> Out=0, Busy=0, Done never pulses. A fresh 6.0/2.0 afterwards completes correctly.
- With FP_DIV_TRISTATE_EN: En=0 -> Out=Z; En=1 -> the held result. Without the macro, Out is independent of En.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared binary32 field widths, constants and FSM state type for the FP divider.
package fp_pkg;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 24;
  localparam int QUOT_W = 25;
  localparam int CNT_W  = 5;

  localparam logic [EXP_W-1:0] BIAS       = 8'd127;
  localparam logic [EXP_W-1:0] FP_INF_EXP = 8'hFF;
  localparam logic [CNT_W-1:0] CNT_START  = 5'd24;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    NORM
  } state_t;
endpackage

// File: rtl/fp_div_normalize.sv
// Combinational normalization of the 25-bit truncated quotient into a fraction
// and exponent; the quotient lies in [0.5, 2) so at most one left shift is needed.
module fp_div_normalize
  import fp_pkg::*;
(
  input  logic [QUOT_W-1:0] quot,
  input  logic [EXP_W-1:0]  exp_tmp,
  output logic [FRAC_W-1:0] frac,
  output logic [EXP_W-1:0]  exp_out
);
  always_comb begin
    if (quot[QUOT_W-1]) begin
      frac    = quot[QUOT_W-2:1];
      exp_out = exp_tmp;
    end else begin
      frac    = quot[FRAC_W-1:0];
      exp_out = exp_tmp - 8'd1;
    end
  end
endmodule

// File: rtl/fp_div.sv
// Sequential binary32 divider: restoring mantissa division, one quotient bit per clock.
// Optional macro FP_DIV_TRISTATE_EN gates Out onto a shared bus using En.
module fp_div
  import fp_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Start,
  input  logic        En,
  input  logic [31:0] InA,
  input  logic [31:0] InB,
  output logic [31:0] Out,
  output logic        Busy,
  output logic        Done
);
  state_t state, state_next;

  logic              a_zero, b_zero, sign;
  logic [EXP_W-1:0]  exp_tmp;
  logic [MANT_W:0]   rem;
  logic [MANT_W-1:0] divisor;
  logic [QUOT_W-1:0] quot;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       out_reg;
  logic              done_reg;

  logic [MANT_W+1:0] trial;
  logic              trial_ok;
  logic [MANT_W:0]   rem_sel;
  logic [FRAC_W-1:0] norm_frac;
  logic [EXP_W-1:0]  norm_exp;

  // Remainder stays below twice the divisor, so one guard bit catches a negative trial.
  assign trial    = {1'b0, rem} - {2'b00, divisor};
  assign trial_ok = ~trial[MANT_W+1];
  assign rem_sel  = trial_ok ? trial[MANT_W:0] : rem;

  fp_div_normalize u_normalize (
    .quot    (quot),
    .exp_tmp (exp_tmp),
    .frac    (norm_frac),
    .exp_out (norm_exp)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = CALC;
      CALC:    if (cnt == '0) state_next = NORM;
      NORM:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state != IDLE);
    Done = done_reg;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      a_zero   <= 1'b0;
      b_zero   <= 1'b0;
      sign     <= 1'b0;
      exp_tmp  <= '0;
      rem      <= '0;
      divisor  <= '0;
      quot     <= '0;
      cnt      <= '0;
      out_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            a_zero  <= (InA == 32'd0);
            b_zero  <= (InB == 32'd0);
            sign    <= InA[31] ^ InB[31];
            exp_tmp <= InA[30:23] - InB[30:23] + BIAS;
            rem     <= {2'b01, InA[FRAC_W-1:0]};
            divisor <= {1'b1, InB[FRAC_W-1:0]};
            quot    <= '0;
            cnt     <= CNT_START;
          end
        end
        CALC: begin
          rem  <= rem_sel << 1;
          quot <= {quot[QUOT_W-2:0], trial_ok};
          cnt  <= cnt - 5'd1;
        end
        NORM: begin
          // Zero dividend wins over zero divisor; -0.0 is not treated as zero.
          if (a_zero)      out_reg <= 32'd0;
          else if (b_zero) out_reg <= {sign, FP_INF_EXP, {FRAC_W{1'b0}}};
          else             out_reg <= {sign, norm_exp, norm_frac};
          done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef FP_DIV_TRISTATE_EN
  assign Out = En ? out_reg : 32'hZZZZZZZZ;
`else
  logic unused_en;
  assign unused_en = En;
  assign Out = out_reg;
`endif
endmodule

// File: tb/tb_fp_div.sv
// Self-checking bench for fp_div: directed cases, randomized operands against an
// arithmetic reference model, handshake, abort-by-reset and output-enable checks.
module tb_fp_div;
  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Start = 1'b0;
  logic        En = 1'b1;
  logic [31:0] InA = '0;
  logic [31:0] InB = '0;
  wire  [31:0] Out;
  logic        Busy;
  logic        Done;

  int compared = 0;
  int mismatched = 0;

  fp_div dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Start (Start),
    .En    (En),
    .InA   (InA),
    .InB   (InB),
    .Out   (Out),
    .Busy  (Busy),
    .Done  (Done)
  );

  always #5 Clk = ~Clk;

  // Reference: integer long division of the mantissas, truncated, then normalized.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint    ma, mb, q;
    int        e;
    logic [7:0]  e8;
    logic [22:0] frac;
    logic        s;
    s = a[31] ^ b[31];
    if (a == 32'd0) return 32'd0;
    if (b == 32'd0) return {s, 8'hFF, 23'd0};
    ma = longint'({1'b1, a[22:0]});
    mb = longint'({1'b1, b[22:0]});
    q  = (ma * 64'd16777216) / mb;
    e  = int'(a[30:23]) - int'(b[30:23]) + 127;
    if (q >= 64'd16777216) begin
      frac = 23'((q / 2) % 64'd8388608);
    end else begin
      frac = 23'(q % 64'd8388608);
      e = e - 1;
    end
    e8 = 8'(e);
    return {s, e8, frac};
  endfunction

  // Issue one Start and wait (bounded) for Done; inputs are scrambled after capture.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output bit busy_ok);
    @(negedge Clk);
    InA = a; InB = b; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    InA = $urandom; InB = $urandom;
    busy_ok = Busy;
    lat = 0;
    while (lat < 40) begin
      @(posedge Clk); #1;
      lat++;
      if (Done) break;
      if (!Busy) busy_ok = 1'b0;
    end
    res = Out;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    #12;
    compared++;
    if (Out !== 32'd0 || Busy !== 1'b0 || Done !== 1'b0) begin
      mismatched++;
      $display("FAIL reset: Out=%h Busy=%b Done=%b, want 0/0/0", Out, Busy, Done);
    end
    @(negedge Clk); Rst_n = 1'b1;
    $display("reset released: Out=%h Busy=%b Done=%b", Out, Busy, Done);
  endtask

  task automatic test_directed();
    logic [31:0] ta[5] = '{32'h40C00000, 32'h3F800000, 32'hC1000000, 32'h00000000, 32'h3F800000};
    logic [31:0] tb[5] = '{32'h40000000, 32'h40400000, 32'h40000000, 32'h40000000, 32'h00000000};
    logic [31:0] tr[5] = '{32'h40400000, 32'h3EAAAAAA, 32'hC0800000, 32'h00000000, 32'h7F800000};
    logic [31:0] res;
    int lat;
    bit busy_ok;
    for (int i = 0; i < 5; i++) begin
      do_op(ta[i], tb[i], res, lat, busy_ok);
      $display("directed %h / %h -> %h (latency %0d)", ta[i], tb[i], res, lat);
      compared++;
      if (res !== tr[i] || res !== ref_div(ta[i], tb[i])) begin
        mismatched++;
        $display("FAIL directed_%0d: Out=%h, want %h", i, res, tr[i]);
      end
      compared++;
      if (lat != 26 || !busy_ok) begin
        mismatched++;
        $display("FAIL latency_%0d: latency=%0d busy_held=%0b, want 26/1", i, lat, busy_ok);
      end
      @(posedge Clk); #1;
      compared++;
      if (Done !== 1'b0 || Out !== tr[i]) begin
        mismatched++;
        $display("FAIL done_pulse_%0d: Done=%b Out=%h, want 0/%h", i, Done, Out, tr[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, res, exp_v;
    int lat;
    bit busy_ok;
    for (int i = 0; i < 24; i++) begin
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: a = 32'd0;
        1: b = 32'd0;
        2: a = 32'h80000000;
        3: b = 32'h80000000;
        default: ;
      endcase
      exp_v = ref_div(a, b);
      do_op(a, b, res, lat, busy_ok);
      $display("random %h / %h -> %h (latency %0d)", a, b, res, lat);
      compared++;
      if (res !== exp_v || lat != 26) begin
        mismatched++;
        $display("FAIL random_%0d: Out=%h lat=%0d, want %h lat=26", i, res, lat, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] first_res;
    // Start pulse at cycle 5 of a busy operation must be ignored.
    @(negedge Clk);
    InA = 32'h40C00000; InB = 32'h40000000; Start = 1'b1;
    @(posedge Clk); #1; Start = 1'b0;
    lat = 0;
    while (lat < 40) begin
      if (lat == 5) begin
        @(negedge Clk);
        InA = 32'h3F800000; InB = 32'h40400000; Start = 1'b1;
        @(posedge Clk); #1; Start = 1'b0;
      end else begin
        @(posedge Clk); #1;
      end
      lat++;
      if (Done) break;
    end
    first_res = Out;
    $display("busy-start op -> %h (latency %0d)", first_res, lat);
    compared++;
    if (first_res !== 32'h40400000 || lat != 26) begin
      mismatched++;
      $display("FAIL ignored_start: Out=%h lat=%0d, want 40400000 lat=26", first_res, lat);
    end
    // Start asserted during the Done cycle is accepted on the next edge.
    InA = 32'hC1000000; InB = 32'h40000000; Start = 1'b1;
    @(posedge Clk); #1; Start = 1'b0;
    compared++;
    if (Busy !== 1'b1) begin
      mismatched++;
      $display("FAIL done_cycle_accept: Busy=%b, want 1", Busy);
    end
    lat = 0;
    while (lat < 40) begin
      @(posedge Clk); #1;
      lat++;
      if (Done) break;
    end
    $display("done-cycle op -> %h (latency %0d)", Out, lat);
    compared++;
    if (Out !== 32'hC0800000 || lat != 26) begin
      mismatched++;
      $display("FAIL back_to_back: Out=%h lat=%0d, want C0800000 lat=26", Out, lat);
    end
  endtask

  task automatic test_abort();
    logic [31:0] res;
    int lat;
    bit busy_ok;
    bit saw_done;
    @(negedge Clk);
    InA = 32'h3F800000; InB = 32'h40400000; Start = 1'b1;
    @(posedge Clk); #1; Start = 1'b0;
    repeat (10) @(posedge Clk);
    @(negedge Clk); Rst_n = 1'b0;
    #1;
    compared++;
    if (Out !== 32'd0 || Busy !== 1'b0 || Done !== 1'b0) begin
      mismatched++;
      $display("FAIL abort: Out=%h Busy=%b Done=%b, want 0/0/0", Out, Busy, Done);
    end
    @(negedge Clk); Rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (30) begin
      @(posedge Clk); #1;
      if (Done || Busy) saw_done = 1'b1;
    end
    $display("abort: Out=%h, activity after reset=%0b", Out, saw_done);
    compared++;
    if (saw_done || Out !== 32'd0) begin
      mismatched++;
      $display("FAIL abort_quiet: activity=%0b Out=%h, want 0/00000000", saw_done, Out);
    end
    do_op(32'h40C00000, 32'h40000000, res, lat, busy_ok);
    $display("post-abort 6/2 -> %h (latency %0d)", res, lat);
    compared++;
    if (res !== 32'h40400000 || lat != 26) begin
      mismatched++;
      $display("FAIL post_abort: Out=%h lat=%0d, want 40400000 lat=26", res, lat);
    end
  endtask

  task automatic test_enable();
    @(negedge Clk); En = 1'b0; #1;
`ifdef FP_DIV_TRISTATE_EN
    compared++;
    if (Out !== 32'hZZZZZZZZ) begin
      mismatched++;
      $display("FAIL enable_off: Out=%h, want zzzzzzzz", Out);
    end
`else
    compared++;
    if (Out !== 32'h40400000) begin
      mismatched++;
      $display("FAIL enable_ignored: Out=%h, want 40400000", Out);
    end
`endif
    $display("En=0: Out=%h", Out);
    @(negedge Clk); En = 1'b1; #1;
    compared++;
    if (Out !== 32'h40400000) begin
      mismatched++;
      $display("FAIL enable_on: Out=%h, want 40400000", Out);
    end
    $display("En=1: Out=%h", Out);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_abort();
    test_enable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
